// File: rtl/axi_arbiter.sv
// Arbitrates IFU fetches and LSU loads/stores onto one AXI4 master port.
// Only one transaction is in flight; the response is returned as a one-cycle pulse to the owner.
module axi_arbiter #(
    parameter int ARB_FAIR = 0
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic [2:0]  lsu_size,

    output logic        ifu_rsp_valid,
    output logic        lsu_rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic        io_master_arvalid,
    input  logic        io_master_arready,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,

    input  logic        io_master_rvalid,
    output logic        io_master_rready,
    input  logic [31:0] io_master_rdata,
    input  logic [1:0]  io_master_rresp,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid,

    output logic        io_master_awvalid,
    input  logic        io_master_awready,
    output logic [31:0] io_master_awaddr,
    output logic [3:0]  io_master_awid,
    output logic [7:0]  io_master_awlen,
    output logic [2:0]  io_master_awsize,
    output logic [1:0]  io_master_awburst,

    output logic        io_master_wvalid,
    input  logic        io_master_wready,
    output logic [31:0] io_master_wdata,
    output logic [3:0]  io_master_wstrb,
    output logic        io_master_wlast,

    input  logic        io_master_bvalid,
    output logic        io_master_bready,
    input  logic [1:0]  io_master_bresp,
    input  logic [3:0]  io_master_bid
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        WR_AWW = 3'd3,
        WR_B   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant;      // 1 = LSU won the most recent grant
    logic        owner_lsu;
    logic        aw_done;
    logic        w_done;
    logic        grant_ifu;
    logic        grant_lsu;
    logic        accept;
    logic        aw_fire;
    logic        w_fire;
    logic        aw_complete;
    logic        w_complete;

    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  wstrb_p0;
    logic [2:0]  size_p0;

    // Transaction IDs are always zero, so returned IDs carry no information.
    logic        unused_ids;
    assign unused_ids = ^{io_master_rid, io_master_bid};

    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (ifu_req_valid && lsu_req_valid) begin
            if (ARB_FAIR != 0) begin
                grant_lsu = !last_grant;
            end else begin
                grant_lsu = 1'b1;
            end
            grant_ifu = !grant_lsu;
        end else begin
            grant_ifu = ifu_req_valid;
            grant_lsu = lsu_req_valid;
        end
    end

    assign ifu_req_ready = (state == IDLE) && grant_ifu;
    assign lsu_req_ready = (state == IDLE) && grant_lsu;
    assign accept        = ifu_req_ready || lsu_req_ready;

    assign io_master_arvalid = (state == RD_AR);
    assign io_master_araddr  = addr_p0;
    assign io_master_arid    = 4'd0;
    assign io_master_arlen   = 8'd0;
    assign io_master_arsize  = size_p0;
    assign io_master_arburst = 2'b01;
    assign io_master_rready  = (state == RD_R);

    assign io_master_awvalid = (state == WR_AWW) && !aw_done;
    assign io_master_awaddr  = addr_p0;
    assign io_master_awid    = 4'd0;
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = 3'd2;
    assign io_master_awburst = 2'b01;
    assign io_master_wvalid  = (state == WR_AWW) && !w_done;
    assign io_master_wdata   = wdata_p0;
    assign io_master_wstrb   = wstrb_p0;
    assign io_master_wlast   = io_master_wvalid;
    assign io_master_bready  = (state == WR_B);

    assign aw_fire     = io_master_awvalid && io_master_awready;
    assign w_fire      = io_master_wvalid && io_master_wready;
    assign aw_complete = aw_done || aw_fire;
    assign w_complete  = w_done || w_fire;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (lsu_req_ready && lsu_wen) begin
                    state_next = WR_AWW;
                end else if (accept) begin
                    state_next = RD_AR;
                end
            end
            RD_AR:  if (io_master_arready) state_next = RD_R;
            RD_R:   if (io_master_rvalid) state_next = IDLE;
            WR_AWW: if (aw_complete && w_complete) state_next = WR_B;
            WR_B:   if (io_master_bvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= 1'b0;
            owner_lsu     <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            rsp_rdata     <= 32'd0;
            rsp_err       <= 1'b0;
        end else begin
            state         <= state_next;
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            if (accept) begin
                last_grant <= lsu_req_ready;
                owner_lsu  <= lsu_req_ready;
            end
            if (state == WR_AWW) begin
                if (aw_complete && w_complete) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                end
            end
            if ((state == RD_R) && io_master_rvalid) begin
                rsp_rdata     <= io_master_rdata;
                rsp_err       <= (io_master_rresp != 2'b00) || !io_master_rlast;
                ifu_rsp_valid <= !owner_lsu;
                lsu_rsp_valid <= owner_lsu;
            end
            if ((state == WR_B) && io_master_bvalid) begin
                rsp_err       <= (io_master_bresp != 2'b00);
                lsu_rsp_valid <= 1'b1;
            end
        end
    end

    // Request capture: fields are frozen for the life of the transaction
    always_ff @(posedge clock) begin
        if (accept) begin
            addr_p0  <= lsu_req_ready ? lsu_addr : ifu_addr;
            size_p0  <= lsu_req_ready ? lsu_size : 3'd2;
            wdata_p0 <= lsu_wdata;
            wstrb_p0 <= lsu_wstrb;
        end
    end

endmodule
